apb_periph_node: RTL

APB_PERIPH_NODE -- requirements
Module: apb_periph_node

---
 rtl/apb_node_pkg.sv | 16 +
 rtl/apb_node_decode.sv | 29 ++
 rtl/apb_periph_node.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/apb_node_pkg.sv
// Shared types and helpers for the APB peripheral node.
// The timeout counter width helper is used only when APB_NODE_TIMEOUT_EN is defined.
package apb_node_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } node_state_e;

    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_node_decode.sv
// Combinational address window decoder for the APB peripheral node.
// Produces a hit flag and the index of the lowest-numbered matching window.
module apb_node_decode
    import apb_node_pkg::*;
#(
    parameter int unsigned NB_PORTS   = 12,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] start_addr [NB_PORTS],
    input  logic [ADDR_WIDTH-1:0] end_addr   [NB_PORTS],
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  index
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = int'(NB_PORTS) - 1; i >= 0; i--) begin
            if ((addr >= start_addr[i]) && (addr <= end_addr[i])) begin
                hit   = 1'b1;
                index = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_node.sv
// APB one-to-many peripheral node: decodes an upstream transfer to one of NB_PORTS ports.
// Define APB_NODE_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_periph_node
    import apb_node_pkg::*;
#(
    parameter int unsigned          NB_PORTS       = 12,
    parameter int unsigned          ADDR_WIDTH     = 32,
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter int unsigned          TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA     = 'hBADACCE5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    input  logic                  pwrite_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [ADDR_WIDTH-1:0] start_addr_i [NB_PORTS],
    input  logic [ADDR_WIDTH-1:0] end_addr_i   [NB_PORTS],
    output logic [ADDR_WIDTH-1:0] m_paddr_o,
    output logic [DATA_WIDTH-1:0] m_pwdata_o,
    output logic                  m_pwrite_o,
    output logic                  m_penable_o,
    output logic [NB_PORTS-1:0]   m_psel_o,
    input  logic [DATA_WIDTH-1:0] m_prdata_i   [NB_PORTS],
    input  logic [NB_PORTS-1:0]   m_pready_i,
    input  logic [NB_PORTS-1:0]   m_pslverr_i,
    output logic                  err_o
);

    localparam int unsigned IDX_WIDTH = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end

    node_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  slverr_q;
    logic                  err_q;

    logic                  accept;
    logic                  dec_hit;
    logic [IDX_WIDTH-1:0]  dec_idx;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_slverr;
    logic                  timeout;

    apb_node_decode #(
        .NB_PORTS   (NB_PORTS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_decode (
        .addr       (paddr_i),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (dec_hit),
        .index      (dec_idx)
    );

    // Only a fresh APB setup phase seen in IDLE starts a transfer.
    assign accept     = (state_q == StIdle) && psel_i && !penable_i;
    assign sel_ready  = m_pready_i[idx_q];
    assign sel_rdata  = m_prdata_i[idx_q];
    assign sel_slverr = m_pslverr_i[idx_q];

`ifdef APB_NODE_TIMEOUT_EN
    localparam int unsigned          CNT_WIDTH = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (accept && dec_hit) begin
            cnt_q <= '0;
        end else if ((state_q == StAccess) && !sel_ready) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // A ready arriving on the final counted cycle still completes normally.
    assign timeout = (state_q == StAccess) && !sel_ready && (cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = dec_hit ? StSetup : StResp;
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (sel_ready || timeout) begin
                    state_d = StResp;
                end
            end
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        m_psel_o    = '0;
        m_penable_o = 1'b0;
        pready_o    = 1'b0;
        pslverr_o   = 1'b0;
        prdata_o    = '0;
        err_o       = 1'b0;
        unique case (state_q)
            StSetup: begin
                m_psel_o[idx_q] = 1'b1;
            end
            StAccess: begin
                m_psel_o[idx_q] = 1'b1;
                m_penable_o     = 1'b1;
            end
            StResp: begin
                pready_o  = 1'b1;
                pslverr_o = slverr_q;
                prdata_o  = prdata_q;
                err_o     = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
            slverr_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= paddr_i;
            wdata_q  <= pwdata_i;
            write_q  <= pwrite_i;
            idx_q    <= dec_idx;
            slverr_q <= !dec_hit;
            err_q    <= !dec_hit;
            prdata_q <= (!dec_hit && !pwrite_i) ? ERR_RDATA : '0;
        end else if ((state_q == StAccess) && sel_ready) begin
            prdata_q <= write_q ? '0 : sel_rdata;
            slverr_q <= sel_slverr;
            err_q    <= 1'b0;
        end else if (timeout) begin
            prdata_q <= write_q ? '0 : ERR_RDATA;
            slverr_q <= 1'b1;
            err_q    <= 1'b1;
        end
    end

    assign m_paddr_o  = addr_q;
    assign m_pwdata_o = wdata_q;
    assign m_pwrite_o = write_q;

endmodule
